// File: rtl/mem_access.sv
// Memory-stage load/store unit: request/grant + rvalid data-memory port, store lane replication, load lane extension.
// Accept->req next cycle; store done 1 cycle after gnt, load done 1 cycle after rvalid; busy stalls upstream meanwhile.
module mem_access #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] s_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [6:0] I_LOAD  = 7'b0000011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;
  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_MIS  = 2'b01;
  localparam logic [1:0] FC_ILL  = 2'b10;
  localparam logic [1:0] FC_TO   = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [7:0]  r_cnt;
  logic [31:0] r_load_data;
  logic        r_fault;
  logic [1:0]  r_code;

  logic        w_is_load, w_is_store, w_accept;
  logic        w_illegal, w_misalign, w_acc_fault;
  logic [1:0]  w_acc_code;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane, w_load_ext;
  logic [8:0]  w_cnt_inc;
  logic        w_timeout;
  logic        w_fin, w_fin_fault, w_busy;
  logic [1:0]  w_fin_code;
  logic [31:0] w_fin_data;

  assign w_is_load  = (op == I_LOAD);
  assign w_is_store = (op == S_TYPE);
  assign w_accept   = start && (w_is_load || w_is_store) && (r_state == IDLE || r_state == DONE);

  assign w_illegal   = w_is_load ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                                 : (funct3 > 3'b010);
  assign w_misalign  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign w_acc_fault = w_illegal || w_misalign;
  assign w_acc_code  = w_illegal ? FC_ILL : (w_misalign ? FC_MIS : FC_NONE);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (w_is_store) begin
      case (funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{s_data[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << addr[1:0];
          w_wdata = {2{s_data[15:0]}};
        end
        default: w_wdata = s_data;
      endcase
    end
  end

  assign w_lane = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_ext = {24'b0, w_lane[7:0]};
      3'b101:  w_load_ext = {16'b0, w_lane[15:0]};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // Counter may already equal MAX_WAIT when a late grant moves us into RESP.
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_timeout = (w_cnt_inc >= 9'(MAX_WAIT));

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_fin       = 1'b0;
    w_fin_fault = 1'b0;
    w_fin_code  = FC_NONE;
    w_fin_data  = '0;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (w_accept) begin
          w_busy = 1'b1;
          if (w_acc_fault) begin
            w_state_nxt = DONE;
            w_fin       = 1'b1;
            w_fin_fault = 1'b1;
            w_fin_code  = w_acc_code;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        w_busy = 1'b1;
        if (mem_gnt) begin
          w_state_nxt = r_we ? DONE : RESP;
          w_fin       = r_we;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
          w_fin       = 1'b1;
          w_fin_fault = 1'b1;
          w_fin_code  = FC_TO;
        end
      end
      RESP: begin
        w_busy = 1'b1;
        if (mem_rvalid) begin
          w_state_nxt = DONE;
          w_fin       = 1'b1;
          w_fin_data  = w_load_ext;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
          w_fin       = 1'b1;
          w_fin_fault = 1'b1;
          w_fin_code  = FC_TO;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_cnt       <= '0;
      r_load_data <= '0;
      r_fault     <= 1'b0;
      r_code      <= FC_NONE;
    end else begin
      if (w_accept) begin
        r_we     <= w_is_store;
        r_addr   <= {addr[31:2], 2'b00};
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_funct3 <= funct3;
        r_off    <= addr[1:0];
        r_cnt    <= '0;
      end else if (r_state == REQ || r_state == RESP) begin
        r_cnt <= w_cnt_inc[7:0];
      end
      // Result registers only change on completion so they hold until the next done.
      if (w_fin) begin
        r_load_data <= w_fin_data;
        r_fault     <= w_fin_fault;
        r_code      <= w_fin_code;
      end
    end
  end

  assign busy       = w_busy;
  assign done       = (r_state == DONE);
  assign mem_req    = (r_state == REQ);
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_be     = r_be;
  assign mem_wdata  = r_wdata;
  assign load_data  = r_load_data;
  assign fault      = r_fault;
  assign fault_code = r_code;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus queues expected completions, negedge monitors check them on done.
module tb_mem_access;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  typedef struct {
    int          id;
    logic [31:0] ld;
    logic        flt;
    logic [1:0]  code;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          done_cyc;
    int          nreq;
    int          nbusy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, start;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [31:0] addr, s_data;
  logic        busy, done, fault, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [1:0]  fault_code;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        t_start;
  logic [31:0] t_addr;
  logic        t_busy, t_done, t_fault, t_req, t_we;
  logic [31:0] t_ld, t_maddr, t_wd;
  logic [1:0]  t_code;
  logic [3:0]  t_be;

  mem_access u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .funct3(funct3), .addr(addr), .s_data(s_data),
    .busy(busy), .done(done), .load_data(load_data), .fault(fault), .fault_code(fault_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  mem_access #(.MAX_WAIT(4)) u_to (
    .clk(clk), .rst(rst), .start(t_start), .op(OP_LOAD), .funct3(3'b010), .addr(t_addr), .s_data(32'h0),
    .busy(t_busy), .done(t_done), .load_data(t_ld), .fault(t_fault), .fault_code(t_code),
    .mem_req(t_req), .mem_we(t_we), .mem_addr(t_maddr), .mem_be(t_be), .mem_wdata(t_wd),
    .mem_gnt(1'b0), .mem_rvalid(1'b0), .mem_rdata(32'hFFFF_FFFF)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic cmp(input exp_t e, input logic [31:0] ld, input logic flt, input logic [1:0] code,
                     input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                     input int nreq, input int nbusy);
    chk($sformatf("tx%0d.done_cycle", e.id), cyc, e.done_cyc);
    chk($sformatf("tx%0d.fault", e.id), 32'(flt), 32'(e.flt));
    chk($sformatf("tx%0d.fault_code", e.id), 32'(code), 32'(e.code));
    chk($sformatf("tx%0d.req_cycles", e.id), nreq, e.nreq);
    chk($sformatf("tx%0d.busy_cycles", e.id), nbusy, e.nbusy);
    if (!e.we && (e.code == 2'b00 || e.code == 2'b11))
      chk($sformatf("tx%0d.load_data", e.id), ld, e.ld);
    if (e.code != 2'b10) begin
      chk($sformatf("tx%0d.mem_we", e.id), 32'(we), 32'(e.we));
      chk($sformatf("tx%0d.mem_addr", e.id), a, e.addr);
      chk($sformatf("tx%0d.mem_be", e.id), 32'(be), 32'(e.be));
      chk($sformatf("tx%0d.mem_wdata", e.id), wd, e.wd);
    end
  endtask

  exp_t q[$];
  exp_t q2[$];
  exp_t m_e, m2_e;
  int m_req = 0, m_busy = 0, m2_req = 0, m2_busy = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_req = 0; m_busy = 0;
    end else begin
      if (done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done cycle=%0d actual=1 expected=0", cyc);
        end else begin
          m_e = q.pop_front();
          cmp(m_e, load_data, fault, fault_code, mem_we, mem_addr, mem_be, mem_wdata, m_req, m_busy);
        end
        m_req = 0; m_busy = 0;
      end
      if (busy) m_busy++;
      if (mem_req) m_req++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      m2_req = 0; m2_busy = 0;
    end else begin
      if (t_done) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_timeout_done cycle=%0d actual=1 expected=0", cyc);
        end else begin
          m2_e = q2.pop_front();
          cmp(m2_e, t_ld, t_fault, t_code, t_we, t_maddr, t_be, t_wd, m2_req, m2_busy);
        end
        m2_req = 0; m2_busy = 0;
      end
      if (t_busy) m2_busy++;
      if (t_req) m2_req++;
    end
  end

  int n_id = 0;

  // gl: cycles of grant delay after the first request cycle; rl: cycles from grant to rvalid (>=1).
  task automatic access(input bit b2b, input logic [6:0] o, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input int gl, input int rl,
                        input logic [31:0] rd, input logic [31:0] e_ld, input logic e_flt,
                        input logic [1:0] e_code, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd);
    exp_t e;
    int   t0;
    if (!b2b) begin @(posedge clk); #1; end
    start = 1'b1; op = o; funct3 = f3; addr = a; s_data = sd;
    t0 = cyc;
    e.id = n_id; n_id++;
    e.ld = e_ld; e.flt = e_flt; e.code = e_code; e.we = (o == OP_STORE);
    e.addr = e_addr; e.be = e_be; e.wd = e_wd;
    if (e_flt) begin
      e.done_cyc = t0 + 1; e.nreq = 0;
    end else if (o == OP_STORE) begin
      e.done_cyc = t0 + gl + 2; e.nreq = gl + 1;
    end else begin
      e.done_cyc = t0 + gl + rl + 2; e.nreq = gl + 1;
    end
    e.nbusy = e.done_cyc - t0;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    if (!e_flt) begin
      repeat (gl) begin @(posedge clk); #1; end
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      if (o == OP_LOAD) begin
        repeat (rl - 1) begin @(posedge clk); #1; end
        mem_rvalid = 1'b1; mem_rdata = rd;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'h0BAD_F00D;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t te;
    int   w;
    rst = 1'b1; start = 1'b0; op = OP_ALU; funct3 = 3'b000; addr = 32'h0; s_data = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0BAD_F00D;
    t_start = 1'b0; t_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.done", 32'(done), 32'h0);
    chk("rst.load_data", load_data, 32'h0);
    chk("rst.fault", 32'(fault), 32'h0);
    chk("rst.fault_code", 32'(fault_code), 32'h0);
    chk("rst.mem_req", 32'(mem_req), 32'h0);
    chk("rst.mem_we", 32'(mem_we), 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_be", 32'(mem_be), 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Timeout instance: grant never comes.
    @(posedge clk); #1;
    t_start = 1'b1; t_addr = 32'h0000_0040;
    te.id = 99; te.ld = 32'h0; te.flt = 1'b1; te.code = 2'b11; te.we = 1'b0;
    te.addr = 32'h0000_0040; te.be = 4'hF; te.wd = 32'h0;
    te.done_cyc = cyc + 5; te.nreq = 4; te.nbusy = 5;
    q2.push_back(te);
    @(posedge clk); #1;
    t_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    //      b2b op        f3      addr          s_data        gl rl rdata         exp_ld        flt  code   e_addr        be     wdata
    access(0, OP_STORE, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0,        32'h0,        1'b0, 2'b00, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF);
    access(0, OP_STORE, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0,        32'h0,        1'b0, 2'b00, 32'h0000_0100, 4'h8, 32'hA5A5_A5A5);
    access(0, OP_STORE, 3'b001, 32'h0000_0102, 32'h0000_1234, 0, 0, 32'h0,        32'h0,        1'b0, 2'b00, 32'h0000_0100, 4'hC, 32'h1234_1234);
    access(0, OP_LOAD,  3'b000, 32'h0000_0201, 32'h0,         0, 1, 32'h80FF_7F01, 32'h0000_007F, 1'b0, 2'b00, 32'h0000_0200, 4'hF, 32'h0);
    access(0, OP_LOAD,  3'b000, 32'h0000_0203, 32'h0,         0, 1, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0, 2'b00, 32'h0000_0200, 4'hF, 32'h0);
    access(0, OP_LOAD,  3'b100, 32'h0000_0202, 32'h0,         0, 1, 32'h80FF_7F01, 32'h0000_00FF, 1'b0, 2'b00, 32'h0000_0200, 4'hF, 32'h0);
    access(0, OP_LOAD,  3'b001, 32'h0000_0202, 32'h0,         0, 1, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0, 2'b00, 32'h0000_0200, 4'hF, 32'h0);
    access(0, OP_LOAD,  3'b101, 32'h0000_0202, 32'h0,         0, 1, 32'h80FF_7F01, 32'h0000_80FF, 1'b0, 2'b00, 32'h0000_0200, 4'hF, 32'h0);
    access(0, OP_LOAD,  3'b010, 32'h0000_0200, 32'h0,         2, 3, 32'h80FF_7F01, 32'h80FF_7F01, 1'b0, 2'b00, 32'h0000_0200, 4'hF, 32'h0);
    access(0, OP_LOAD,  3'b010, 32'h0000_0102, 32'h0,         0, 0, 32'h0,        32'h0,        1'b1, 2'b01, 32'h0000_0100, 4'hF, 32'h0);
    access(0, OP_LOAD,  3'b111, 32'h0000_0200, 32'h0,         0, 0, 32'h0,        32'h0,        1'b1, 2'b10, 32'h0000_0200, 4'hF, 32'h0);
    access(0, OP_STORE, 3'b100, 32'h0000_0200, 32'h0000_0077, 0, 0, 32'h0,        32'h0,        1'b1, 2'b10, 32'h0000_0200, 4'h1, 32'h7777_7777);
    access(0, OP_STORE, 3'b010, 32'h0000_0300, 32'h1122_3344, 1, 0, 32'h0,        32'h0,        1'b0, 2'b00, 32'h0000_0300, 4'hF, 32'h1122_3344);
    access(1, OP_LOAD,  3'b010, 32'h0000_0304, 32'h0,         0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2'b00, 32'h0000_0304, 4'hF, 32'h0);

    // Non-memory opcode is ignored.
    @(posedge clk); #1;
    start = 1'b1; op = OP_ALU; funct3 = 3'b000; addr = 32'h0000_0500;
    chk("alu_op.busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("alu_op.done", 32'(done), 32'h0);
    chk("alu_op.mem_req", 32'(mem_req), 32'h0);

    // Reset while waiting for load data; late rvalid/gnt must be ignored.
    @(posedge clk); #1;
    start = 1'b1; op = OP_LOAD; funct3 = 3'b010; addr = 32'h0000_0600;
    @(posedge clk); #1;
    start = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h1357_9BDF;
    chk("rst_mid.mem_req", 32'(mem_req), 32'h0);
    chk("rst_mid.done", 32'(done), 32'h0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'h0BAD_F00D;
    chk("rst_mid.busy", 32'(busy), 32'h0);
    chk("rst_mid.done2", 32'(done), 32'h0);
    chk("rst_mid.mem_req2", 32'(mem_req), 32'h0);
    chk("rst_mid.load_data", load_data, 32'h0);
    chk("rst_mid.fault", 32'(fault), 32'h0);
    chk("rst_mid.fault_code", 32'(fault_code), 32'h0);
    chk("rst_mid.mem_we", 32'(mem_we), 32'h0);
    chk("rst_mid.mem_addr", mem_addr, 32'h0);
    chk("rst_mid.mem_be", 32'(mem_be), 32'h0);
    chk("rst_mid.mem_wdata", mem_wdata, 32'h0);

    access(0, OP_STORE, 3'b010, 32'h0000_0400, 32'h55AA_55AA, 0, 0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0000_0400, 4'hF, 32'h55AA_55AA);

    w = 0;
    while ((q.size() != 0 || q2.size() != 0) && w < 20) begin
      @(posedge clk);
      w++;
    end
    #1;
    while (q.size() != 0) begin
      te = q.pop_front();
      checks++; errors++;
      $display("FAIL missing_done tx%0d actual=none expected=done@%0d", te.id, te.done_cyc);
    end
    while (q2.size() != 0) begin
      te = q2.pop_front();
      checks++; errors++;
      $display("FAIL missing_timeout_done tx%0d actual=none expected=done@%0d", te.id, te.done_cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
